fetch_align_stage: RTL and testbench
====================================

Name: fetch_align_stage

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Prefetches 32-bit words from instruction memory into a small word FIFO.
- Realigns mixed 16/32-bit (RVC) instructions, including 32-bit instructions straddling a word boundary.
- Presents one registered {done, pc, instr} per cycle to decode. Honours decode stall and pipeline redirects (jump, trap, mret).

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4, word FIFO entries; power of 2, minimum 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_valid  out  1  fetch request; held until imem_ready.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_ready  in  1  request complete; imem_rdata is valid in this cycle.
- imem_rdata  in  32  fetched word, little-endian halfwords.
- stall  in  1  decode cannot accept; hold the outputs.
- redirect  in  1  flush and restart (decode jump, csr trap/mret, fence clear).
- redirect_pc  in  32  restart target; bit 0 is ignored.
- f_done  out  1  f_pc/f_instr are a valid instruction.
- f_pc  out  32  address of the presented instruction.
- f_instr  out  32  instruction; compressed forms are zero-extended in [31:16]=0.

Behaviour:
- Reset (async, active-high) clears these outputs:
  - imem_valid=0, imem_addr=0, f_done=0, f_pc=0, f_instr=32'h00000013 (nop).
  - FIFO empty, fetch address = RESET_PC, align pc = RESET_PC, discard flag = 0.
- Reset asserted mid-request abandons the request. Any imem_ready arriving while in reset is ignored.
- Prefetcher:
  - Exactly one outstanding request at a time.
  - imem_valid=1 when no request is outstanding and (FIFO count + in-flight) < DEPTH.
  - On imem_valid && imem_ready, push imem_rdata (unless discarding) and advance fetch address by 4. Wrap-around 32'hFFFFFFFC -> 0 is unflagged.
  - The next request may start the cycle after completion. imem_addr holds stable while imem_valid=1.
- Aligner (combinational on FIFO head, result registered into the f_* outputs when not stalled):
  - pc[1]=0, low head[1:0]==2'b11: instr=head word; pop 1; pc+=4.
  - pc[1]=0, compressed: instr={16'h0,head[15:0]}; no pop; pc+=2.
  - pc[1]=1, head[17:16]!=2'b11: instr={16'h0,head[31:16]}; pop 1; pc+=2.
  - pc[1]=1, 32-bit straddle: requires count>=2. instr={next[15:0],head[31:16]}; pop 1; pc+=4.
  - Insufficient data: register f_done=0, f_instr=nop, f_pc=0. pc is unchanged.
- Output latency: a word arriving at edge N (ready in cycle N) appears with f_done=1 after edge N+1 at the earliest.
- FIFO bypass is not required.
- Stall (stall=1, redirect=0):
  - The f_* registers hold their values.
  - The aligner does not pop or advance.
  - The prefetcher continues while space remains.
- Redirect (priority over stall):
  - FIFO flushed; align pc = {redirect_pc[31:1],1'b0}; fetch address = redirect_pc & ~3.
  - f_done=0, f_instr=nop on the next edge.
  - If a request is outstanding, set the discard flag. The request stays held to completion, its data is dropped, and the new fetch issues the following cycle.
  - If imem_ready coincides with redirect, that data is dropped and no discard flag is set.
  - A second redirect while discarding keeps the discard flag and updates the target.
- Redirect target with bit1=1: the low half of the first fetched word is skipped.
- Full FIFO: no request is issued. A push and a pop in the same cycle are allowed when count==DEPTH-1+in-flight.

Decomposition:
- Shared package additions:
  - nop_instr.
  - fetch_reg_type (pc, instr, done, discard, fetch address, pending).
  - init_fetch_reg.
  - A fetch_out_type bundle {done, pc, instr} to become decode's a.f.
- Sub-module fetch_buffer:
  - Parameterised DEPTH word FIFO, async-reset pointers.
  - Ports: push, wdata, pop, flush, head, next, count.
- Alignment and prefetch logic stay in fetch_align_stage.

Test Plan:
- Reset release, memory of four 32-bit nops from 0, zero-wait ready -> imem_addr 0,4,8,...; f_pc 0,4,8 with f_done=1 from about cycle 3.
- Word 0 = 32'h4501_4505 (two c.li) -> f_instr 32'h00004505 at pc 0, then 32'h00004501 at pc 2; one word popped.
- Straddle: word0 = {16'h0513,16'h4505}, word1 low half 16'h0000 -> pc 0 c.li, then pc 2 f_instr 32'h00000513; next pc 6.
- Hold stall=1 for 3 cycles while f_done=1 at pc 8 -> f_pc/f_instr unchanged; imem stops after DEPTH words buffered; resumes after release.
- Redirect to 32'h00000102 while a request is outstanding with ready delayed 2 cycles:
  - Stale data is dropped; next f_done=0.
  - Fetch at 32'h100; the first instruction shown has f_pc 32'h102 (upper half).
- Redirect in the same cycle as imem_ready -> that word never appears on f_instr; no extra imem cycle is lost.

Source files
------------

// File: rtl/fetch_align_stage_pkg.sv
// Shared types for the instruction fetch/align stage and its consumers.
// fetch_out_type is the bundle decode receives as its fetch input.
package fetch_align_stage_pkg;

  localparam logic [31:0] nop_instr = 32'h0000_0013;

  typedef struct packed {
    logic        done;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_out_type;

  typedef struct packed {
    fetch_out_type f;
    logic [31:0]   pc;
    logic          discard;
    logic [31:0]   fetch_addr;
    logic          pending;
    logic [31:0]   req_addr;
  } fetch_reg_type;

  function automatic fetch_reg_type init_fetch_reg(input logic [31:0] reset_pc);
    fetch_reg_type r;
    r.f.done     = 1'b0;
    r.f.pc       = 32'h0;
    r.f.instr    = nop_instr;
    r.pc         = reset_pc;
    r.discard    = 1'b0;
    r.fetch_addr = reset_pc;
    r.pending    = 1'b0;
    r.req_addr   = 32'h0;
    return r;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small word FIFO between the prefetcher and the aligner.
// Exposes the head word and the word behind it so straddling instructions can be assembled.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [31:0]            wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [31:0]            head,
  output logic [31:0]            next,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head = mem[rd_ptr];
  assign next = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/fetch_align_stage.sv
// Instruction fetch stage: single-outstanding prefetcher into a word FIFO, then
// RVC-aware realignment into a registered {done, pc, instr} for decode.
module fetch_align_stage
  import fetch_align_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        f_done,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  fetch_reg_type fetch_p1;
  fetch_reg_type fetch_p0;

  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [31:0]   head;
  logic [31:0]   next_word;
  logic          push;
  logic          pop;
  logic          complete;
  logic          al_ok;
  logic          al_pop;
  logic [31:0]   al_instr;
  logic [31:0]   al_pc;
  logic          unused_pc_bit0;

  assign unused_pc_bit0 = redirect_pc[0];

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_buffer (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (imem_rdata),
    .pop   (pop),
    .flush (redirect),
    .head  (head),
    .next  (next_word),
    .count (count)
  );

  // Stage p0: align the FIFO head at the current pc
  always_comb begin
    al_ok    = 1'b0;
    al_pop   = 1'b0;
    al_instr = nop_instr;
    al_pc    = fetch_p1.pc;
    if (count != '0) begin
      if (!fetch_p1.pc[1]) begin
        al_ok = 1'b1;
        if (head[1:0] == 2'b11) begin
          al_instr = head;
          al_pop   = 1'b1;
          al_pc    = fetch_p1.pc + 32'd4;
        end else begin
          al_instr = {16'h0000, head[15:0]};
          al_pc    = fetch_p1.pc + 32'd2;
        end
      end else if (head[17:16] != 2'b11) begin
        al_ok    = 1'b1;
        al_instr = {16'h0000, head[31:16]};
        al_pop   = 1'b1;
        al_pc    = fetch_p1.pc + 32'd2;
      end else if (count > ONE_C) begin
        al_ok    = 1'b1;
        al_instr = {next_word[15:0], head[31:16]};
        al_pop   = 1'b1;
        al_pc    = fetch_p1.pc + 32'd4;
      end
    end
  end

  assign complete = fetch_p1.pending & imem_ready;
  assign push     = complete & ~fetch_p1.discard & ~redirect;
  assign pop      = al_pop & ~stall & ~redirect;
  assign count_n  = redirect ? '0
                  : count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  always_comb begin
    fetch_p0 = fetch_p1;
    if (redirect) begin
      fetch_p0.f          = '{done: 1'b0, pc: 32'h0, instr: nop_instr};
      fetch_p0.pc         = {redirect_pc[31:1], 1'b0};
      fetch_p0.fetch_addr = {redirect_pc[31:2], 2'b00};
      // A still-open request must run to completion; its data is stale.
      fetch_p0.discard    = fetch_p1.pending & ~imem_ready;
    end else begin
      if (complete) begin
        if (!fetch_p1.discard) fetch_p0.fetch_addr = fetch_p1.fetch_addr + 32'd4;
        fetch_p0.discard = 1'b0;
      end
      if (!stall) begin
        fetch_p0.f.done  = al_ok;
        fetch_p0.f.pc    = al_ok ? fetch_p1.pc : 32'h0;
        fetch_p0.f.instr = al_instr;
        fetch_p0.pc      = al_pc;
      end
    end
    if (fetch_p1.pending && !imem_ready) begin
      fetch_p0.pending = 1'b1;
    end else begin
      fetch_p0.pending  = (count_n < DEPTH_C);
      fetch_p0.req_addr = fetch_p0.fetch_addr;
    end
  end

  // Stage p1: registered state and decode-facing outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) fetch_p1 <= init_fetch_reg(RESET_PC);
    else       fetch_p1 <= fetch_p0;
  end

  assign imem_valid = fetch_p1.pending;
  assign imem_addr  = fetch_p1.req_addr;
  assign f_done     = fetch_p1.f.done;
  assign f_pc       = fetch_p1.f.pc;
  assign f_instr    = fetch_p1.f.instr;

endmodule

// File: tb/tb_fetch_align_stage.sv
// Self-checking bench for fetch_align_stage: directed scenarios followed by a
// randomized run against an instruction-stream model of memory.
module tb_fetch_align_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        f_done;
  logic [31:0] f_pc;
  logic [31:0] f_instr;

  fetch_align_stage #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .f_done     (f_done),
    .f_pc       (f_pc),
    .f_instr    (f_instr)
  );

  always #5 clock = ~clock;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] mem [128];
  int          lat_fixed = 0;
  int          wait_cnt  = 0;
  bit          req_seen  = 0;
  bit          stale     = 0;
  logic [31:0] exp_pc    = 32'h0;
  logic [31:0] exp_faddr = 32'h0;
  bit          held_prev = 0;
  logic [31:0] held_addr = 32'h0;
  bit          hold_prev = 0;
  bit          redir_prev = 0;
  logic        sv_done;
  logic [31:0] sv_pc;
  logic [31:0] sv_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem[a[8:2]];
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction at a byte address: 32-bit when the low parcel ends in 2'b11.
  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    logic [15:0] lo;
    lo = half_at(pc);
    if (lo[1:0] == 2'b11) return {half_at(pc + 32'd2), lo};
    return {16'h0000, lo};
  endfunction

  function automatic logic [31:0] instr_len(input logic [31:0] pc);
    logic [15:0] lo;
    lo = half_at(pc);
    return (lo[1:0] == 2'b11) ? 32'd4 : 32'd2;
  endfunction

  task automatic fill_nop();
    for (int i = 0; i < 128; i++) mem[i] = NOP;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    stall      = 1'b0;
    redirect   = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_imem_valid", imem_valid, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_f_done", f_done, 0);
    chk("rst_f_pc", f_pc, 0);
    chk("rst_f_instr", f_instr, NOP);
    repeat (2) @(negedge clock);
    chk("rst_hold_valid", imem_valid, 0);
    chk("rst_hold_done", f_done, 0);
    imem_ready = 1'b0;
    reset      = 1'b0;
    exp_pc     = 32'h0;
    exp_faddr  = 32'h0;
    stale      = 0;
    req_seen   = 0;
    held_prev  = 0;
    hold_prev  = 0;
    redir_prev = 0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    logic comp;
    if (imem_valid) begin
      if (!req_seen) begin
        req_seen = 1;
        wait_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end
      if (wait_cnt == 0) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        wait_cnt--;
      end
    end else begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
    end
    comp = imem_valid & imem_ready;

    if (held_prev) begin
      chk("imem_valid_held", imem_valid, 1);
      chk("imem_addr_held", imem_addr, held_addr);
    end
    if (imem_valid) chk("imem_addr_aligned", imem_addr[1:0], 0);
    if (hold_prev) begin
      chk("stall_hold_done", f_done, sv_done);
      chk("stall_hold_pc", f_pc, sv_pc);
      chk("stall_hold_instr", f_instr, sv_instr);
    end
    if (redir_prev) chk("redirect_bubble", f_done, 0);
    if (!f_done) begin
      chk("idle_instr_nop", f_instr, NOP);
      chk("idle_pc_zero", f_pc, 0);
    end

    if (comp) begin
      if (stale) stale = 0;
      else begin
        chk("fetch_addr_seq", imem_addr, exp_faddr);
        exp_faddr = exp_faddr + 32'd4;
      end
      req_seen = 0;
    end

    if (redirect) begin
      stale     = imem_valid & ~imem_ready;
      exp_faddr = {redirect_pc[31:2], 2'b00};
      exp_pc    = {redirect_pc[31:1], 1'b0};
    end else if (!stall && f_done) begin
      chk("stream_pc", f_pc, exp_pc);
      chk("stream_instr", f_instr, instr_at(exp_pc));
      exp_pc = exp_pc + instr_len(exp_pc);
    end

    held_prev  = imem_valid & ~imem_ready;
    held_addr  = imem_addr;
    hold_prev  = stall & ~redirect;
    redir_prev = redirect;
    sv_done    = f_done;
    sv_pc      = f_pc;
    sv_instr   = f_instr;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clock);

    // Straight-line 32-bit nops, zero-wait memory, then a long stall.
    fill_nop();
    lat_fixed = 0;
    do_reset();
    tick();
    chk("t1_first_valid", imem_valid, 1);
    chk("t1_first_addr", imem_addr, 32'h0);
    tick();
    chk("t1_second_addr", imem_addr, 32'h4);
    tick();
    chk("t1_first_done", f_done, 1);
    chk("t1_pc0", f_pc, 32'h0);
    tick();
    chk("t1_pc4", f_pc, 32'h4);
    tick();
    chk("t1_pc8", f_pc, 32'h8);
    stall = 1'b1;
    repeat (6) tick();
    chk("t1_stall_pc", f_pc, 32'h8);
    chk("t1_stall_instr", f_instr, NOP);
    chk("t1_full_no_req", imem_valid, 0);
    stall = 1'b0;
    tick();
    chk("t1_resume_req", imem_valid, 1);
    repeat (4) tick();

    // Two compressed instructions in one word.
    fill_nop();
    mem[0] = 32'h4501_4505;
    do_reset();
    repeat (3) tick();
    chk("t2_c0_instr", f_instr, 32'h0000_4505);
    chk("t2_c0_pc", f_pc, 32'h0);
    tick();
    chk("t2_c1_instr", f_instr, 32'h0000_4501);
    chk("t2_c1_pc", f_pc, 32'h2);
    tick();
    chk("t2_next_pc", f_pc, 32'h4);
    chk("t2_next_instr", f_instr, NOP);

    // 32-bit instruction straddling a word boundary.
    fill_nop();
    mem[0] = 32'h0513_4505;
    mem[1] = 32'h4505_0000;
    do_reset();
    repeat (3) tick();
    chk("t3_c_instr", f_instr, 32'h0000_4505);
    tick();
    chk("t3_straddle_pc", f_pc, 32'h2);
    chk("t3_straddle_instr", f_instr, 32'h0000_0513);
    tick();
    chk("t3_after_pc", f_pc, 32'h6);
    chk("t3_after_instr", f_instr, 32'h0000_4505);
    tick();
    chk("t3_word2_pc", f_pc, 32'h8);

    // Redirect to an upper half while a slow request is outstanding.
    fill_nop();
    mem[0]  = 32'h00A0_0093;
    mem[64] = 32'h4505_0001;
    lat_fixed = 2;
    do_reset();
    tick();
    chk("t4_req_open", imem_valid, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    chk("t4_bubble", f_done, 0);
    chk("t4_addr_held", imem_addr, 32'h0);
    for (int i = 0; i < 20 && !f_done; i++) tick();
    chk("t4_reached", f_done, 1);
    chk("t4_first_pc", f_pc, 32'h0000_0102);
    chk("t4_first_instr", f_instr, 32'h0000_4505);
    repeat (4) tick();

    // Redirect in the same cycle the memory answers.
    fill_nop();
    mem[3]  = 32'h00A0_0093;
    mem[16] = 32'h4501_4505;
    lat_fixed = 0;
    do_reset();
    repeat (4) tick();
    chk("t5_ready_cycle", imem_valid, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    chk("t5_no_lost_cycle", imem_valid, 1);
    chk("t5_new_addr", imem_addr, 32'h0000_0040);
    repeat (6) tick();

    // Randomized program, memory latency, stalls, redirects and a mid-run reset.
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    lat_fixed = -1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
      end else begin
        stall       = ($urandom_range(0, 3) == 0);
        redirect    = ($urandom_range(0, 40) == 0);
        redirect_pc = 32'($urandom_range(0, 511));
        tick();
      end
    end
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
